// File: rtl/trig_out_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trig_out_scheduler_pkg
// Description : Shared widths, state encodings and helpers for the Trigger
//               Out scheduler and its event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package trig_out_scheduler_pkg;

    localparam int c_TRIG_W    = 32;
    localparam int c_BIT_IDX_W = 5;

    // Scheduler state encodings
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_PULSE = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    localparam logic [15:0] c_DISCARD_MAX = 16'hFFFF;

    // One-hot trigger vector for a bit index
    function automatic logic [c_TRIG_W-1:0] bit_onehot(input logic [c_BIT_IDX_W-1:0] idx);
        logic [c_TRIG_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trig_sched_fifo
// Description : Synchronous show-ahead FIFO holding queued trigger bit
//               indices. Clear empties it; push when full and pop when empty
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                         ep_clk,
    input  logic                         ep_reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == c_LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full & ~clear;
    assign w_do_pop  = pop & ~empty & ~clear;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge ep_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + c_LW'(w_do_push) - c_LW'(w_do_pop);
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge ep_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/trig_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : trig_out_scheduler
// Description : Round-robin arbitration of NREQ trigger requesters into an
//               event FIFO, drained as one-cycle pulses on a 32-bit Trigger
//               Out vector. Back-to-back equal bits get a zero cycle between
//               them so every event shows a rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_out_scheduler
    import trig_out_scheduler_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int QDEPTH = 8
) (
    input  logic                          ep_clk,
    input  logic                          ep_reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [c_TRIG_W-1:0]           cfg_mask,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*c_BIT_IDX_W-1:0]   req_bit,
    output logic [NREQ-1:0]               req_ready,
    output logic [c_TRIG_W-1:0]           ep_trigger,
    output logic [$clog2(QDEPTH+1)-1:0]   fifo_level,
    output logic                          busy,
    output logic [15:0]                   discard_count
);

    localparam int c_PTR_W = $clog2(NREQ);

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [1:0]             r_state;
    logic [c_BIT_IDX_W-1:0] r_last_bit;
    logic [c_TRIG_W-1:0]    r_trigger;
    logic [15:0]            r_discard_count;

    logic [c_PTR_W-1:0]     w_cand;
    logic [c_PTR_W-1:0]     w_grant_idx;
    logic                   w_grant_found;
    logic                   w_ready_en;
    logic [c_BIT_IDX_W-1:0] w_din;
    logic [c_BIT_IDX_W-1:0] w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [1:0]             w_state_nxt;
    logic [c_BIT_IDX_W-1:0] w_last_nxt;
    logic                   w_pop;
    logic                   w_discard;

    trig_sched_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (c_BIT_IDX_W)
    ) u_fifo (
        .ep_clk   (ep_clk),
        .ep_reset (ep_reset),
        .clear    (flush),
        .push     (w_ready_en),
        .pop      (w_pop),
        .din      (w_din),
        .dout     (w_head),
        .level    (fifo_level),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        w_cand        = '0;
        w_grant_idx   = '0;
        w_grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // A grant becomes a transfer only with room in the queue and no flush
    assign w_ready_en = w_grant_found & ~w_fifo_full & ~flush & ~ep_reset;

    // One-hot ready and selection of the granted requester's bit index
    always_comb begin
        req_ready = '0;
        w_din     = '0;
        if (w_ready_en) req_ready[w_grant_idx] = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == c_PTR_W'(k)) w_din = req_bit[k*c_BIT_IDX_W +: c_BIT_IDX_W];
        end
    end

    // Pointer moves just past the requester that transferred
    always_ff @(posedge ep_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_rr_ptr <= '0;
        end else if (w_ready_en) begin
            r_rr_ptr <= (w_grant_idx == c_PTR_W'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Scheduler next state: discard masked heads, gap repeated bits, else pulse
    always_comb begin
        w_state_nxt = c_S_IDLE;
        w_last_nxt  = r_last_bit;
        w_pop       = 1'b0;
        w_discard   = 1'b0;
        if (!flush && enable && !w_fifo_empty) begin
            if (!cfg_mask[w_head]) begin
                w_pop     = 1'b1;
                w_discard = 1'b1;
            end else if ((w_head == r_last_bit) && (r_state == c_S_PULSE)) begin
                w_state_nxt = c_S_GAP;
            end else begin
                w_pop       = 1'b1;
                w_last_nxt  = w_head;
                w_state_nxt = c_S_PULSE;
            end
        end
    end

    // State and registered trigger vector; reset clears the output at once
    always_ff @(posedge ep_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_state    <= c_S_IDLE;
            r_last_bit <= '0;
            r_trigger  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_bit <= w_last_nxt;
            r_trigger  <= (w_state_nxt == c_S_PULSE) ? bit_onehot(w_last_nxt) : '0;
        end
    end

    // Saturating count of entries dropped by the mask
    always_ff @(posedge ep_clk or posedge ep_reset) begin
        if (ep_reset) begin
            r_discard_count <= '0;
        end else if (w_discard && (r_discard_count != c_DISCARD_MAX)) begin
            r_discard_count <= r_discard_count + 16'd1;
        end
    end

    assign ep_trigger    = r_trigger;
    assign discard_count = r_discard_count;
    assign busy          = (fifo_level != '0) | (r_trigger != '0);

endmodule
`default_nettype wire

// File: tb/tb_trig_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_out_scheduler
// Description : Self-checking bench for trig_out_scheduler: vector table,
//               directed multi-cycle sequences and randomized traffic against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_out_scheduler;

    localparam int NREQ   = 4;
    localparam int QDEPTH = 8;

    logic        ep_clk = 1'b0;
    logic        ep_reset;
    logic        enable;
    logic        flush;
    logic [31:0] cfg_mask;
    logic [3:0]  req_valid;
    logic [19:0] req_bit;
    logic [3:0]  req_ready;
    logic [31:0] ep_trigger;
    logic [3:0]  fifo_level;
    logic        busy;
    logic [15:0] discard_count;

    int n_checks = 0;
    int n_fail   = 0;

    trig_out_scheduler #(
        .NREQ   (NREQ),
        .QDEPTH (QDEPTH)
    ) dut (
        .ep_clk        (ep_clk),
        .ep_reset      (ep_reset),
        .enable        (enable),
        .flush         (flush),
        .cfg_mask      (cfg_mask),
        .req_valid     (req_valid),
        .req_bit       (req_bit),
        .req_ready     (req_ready),
        .ep_trigger    (ep_trigger),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .discard_count (discard_count)
    );

    always #5 ep_clk = ~ep_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [19:0] bits;
        logic [3:0]  exp_ready;
        logic [31:0] exp_trig;
        int          exp_level;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int          mq[$];
    int          mptr;
    logic [31:0] mtrig;
    int          mdisc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] pk(input int b0, input int b1, input int b2, input int b3);
        return {5'(b3), 5'(b2), 5'(b1), 5'(b0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [19:0] b, input logic [3:0] r,
                                input logic [31:0] t, input int l, input logic bz);
        vec_t x;
        x.valid = v; x.bits = b; x.exp_ready = r; x.exp_trig = t; x.exp_level = l; x.exp_busy = bz;
        return x;
    endfunction

    function automatic int bit_of(input logic [31:0] t);
        int r;
        r = -1;
        if ($countones(t) == 1) for (int b = 0; b < 32; b++) if (t[b]) r = b;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int pulses[$];
        int waited;
        bit found;
        logic [19:0] B4, A1, B7;
        logic [3:0]  m_ready;
        int          m_g;

        // ---------------- reset state ----------------
        ep_reset = 1'b1; enable = 1'b1; flush = 1'b0; cfg_mask = '1;
        req_valid = 4'b1111; req_bit = '0;
        @(negedge ep_clk);
        @(negedge ep_clk); #1;
        chk("rst_trigger", ep_trigger, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_discard", 32'(discard_count), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(negedge ep_clk);
        ep_reset = 1'b0; req_valid = '0;

        // ---------------- vector table ----------------
        B4 = pk(0, 1, 2, 3);
        A1 = pk(3, 0, 0, 0);
        B7 = pk(0, 7, 0, 0);
        // all four contend from pointer 0
        tbl.push_back(mk(4'b1111, B4, 4'b0001, 32'h0, 0, 1'b0));
        tbl.push_back(mk(4'b1110, B4, 4'b0010, 32'h0, 1, 1'b1));
        tbl.push_back(mk(4'b1100, B4, 4'b0100, 32'h1, 1, 1'b1));
        tbl.push_back(mk(4'b1000, B4, 4'b1000, 32'h2, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h4, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h8, 0, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h0, 0, 1'b0));
        // single bit 3 from requester 0
        tbl.push_back(mk(4'b0001, A1, 4'b0001, 32'h0, 0, 1'b0));
        tbl.push_back(mk(4'b0000, A1, 4'b0000, 32'h0, 1, 1'b1));
        tbl.push_back(mk(4'b0000, A1, 4'b0000, 32'h8, 0, 1'b1));
        tbl.push_back(mk(4'b0000, A1, 4'b0000, 32'h0, 0, 1'b0));
        // bit 7 twice from requester 1: pulse, gap, pulse
        tbl.push_back(mk(4'b0010, B7, 4'b0010, 32'h0, 0, 1'b0));
        tbl.push_back(mk(4'b0010, B7, 4'b0010, 32'h0, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B7, 4'b0000, 32'h80, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B7, 4'b0000, 32'h0, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B7, 4'b0000, 32'h80, 0, 1'b1));
        tbl.push_back(mk(4'b0000, B7, 4'b0000, 32'h0, 0, 1'b0));
        // contention with pointer at 2
        tbl.push_back(mk(4'b1111, B4, 4'b0100, 32'h0, 0, 1'b0));
        tbl.push_back(mk(4'b1011, B4, 4'b1000, 32'h0, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h4, 1, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h8, 0, 1'b1));
        tbl.push_back(mk(4'b0000, B4, 4'b0000, 32'h0, 0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge ep_clk);
            req_valid = tbl[i].valid; req_bit = tbl[i].bits;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_trig", i), ep_trigger, tbl[i].exp_trig);
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end

        // ---------------- full queue with enable low ----------------
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ep_clk);
            enable = 1'b0; req_valid = 4'b0001; req_bit = 20'(8 + accepted);
            #1;
            chk($sformatf("full_ready%0d", c), 32'(req_ready), (c < 8) ? 32'h1 : 32'h0);
            chk("full_no_pulse", ep_trigger, 0);
            if (req_ready[0]) accepted++;
        end
        chk("full_level", 32'(fifo_level), 8);
        chk("full_accepted", 32'(accepted), 8);

        waited = 0;
        while (pulses.size() < 10 && waited < 30) begin
            @(negedge ep_clk);
            enable = 1'b1;
            req_valid = (accepted < 10) ? 4'b0001 : 4'b0000;
            req_bit = 20'(8 + accepted);
            #1;
            if (ep_trigger != 0) pulses.push_back(bit_of(ep_trigger));
            if (req_ready[0] && req_valid[0]) accepted++;
            waited++;
        end
        chk("drain_pulse_count", 32'(pulses.size()), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("drain_bit%0d", i), 32'((i < pulses.size()) ? pulses[i] : -1), 32'(8 + i));
        chk("drain_accepted", 32'(accepted), 10);

        // ---------------- masked bit discards ----------------
        for (int c = 0; c < 8; c++) begin
            @(negedge ep_clk);
            cfg_mask = ~32'h20;
            req_valid = (c < 3) ? 4'b0010 : 4'b0000;
            req_bit = pk(0, 5, 0, 0);
            #1;
            if (c < 3) chk("mask_ready", 32'(req_ready), 32'h2);
            chk("mask_no_pulse", ep_trigger, 0);
        end
        chk("mask_discard", 32'(discard_count), 3);
        chk("mask_level", 32'(fifo_level), 0);
        chk("mask_busy", 32'(busy), 0);

        // ---------------- reset during a pulse ----------------
        for (int c = 0; c < 5; c++) begin
            @(negedge ep_clk);
            cfg_mask = '1; enable = 1'b0;
            req_valid = 4'b0010; req_bit = pk(0, 20 + c, 0, 0);
            #1;
            chk("mid_ready", 32'(req_ready), 32'h2);
        end
        found = 1'b0; waited = 0;
        while (!found && waited < 6) begin
            @(negedge ep_clk);
            enable = 1'b1; req_valid = '0;
            #1;
            if (ep_trigger != 0) found = 1'b1;
            waited++;
        end
        chk("mid_pulse_seen", 32'(found), 1);
        chk("mid_pulse_bit", ep_trigger, 32'h0010_0000);
        chk("mid_level", 32'(fifo_level), 4);
        #2;
        ep_reset = 1'b1;
        #1;
        chk("async_rst_trig", ep_trigger, 0);
        chk("async_rst_level", 32'(fifo_level), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge ep_clk);
        ep_reset = 1'b0; req_valid = 4'b1111; req_bit = pk(0, 1, 2, 3);
        #1;
        chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        @(negedge ep_clk); req_valid = '0; #1;
        chk("post_rst_level", 32'(fifo_level), 1);
        @(negedge ep_clk); #1;
        chk("post_rst_pulse", ep_trigger, 32'h1);
        @(negedge ep_clk); #1;
        chk("post_rst_idle", ep_trigger, 0);
        chk("post_rst_busy", 32'(busy), 0);

        // ---------------- randomized traffic vs model ----------------
        @(negedge ep_clk);
        ep_reset = 1'b1; req_valid = '0;
        @(negedge ep_clk);
        ep_reset = 1'b0;
        mq.delete(); mptr = 0; mtrig = '0; mdisc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge ep_clk);
            if (cyc % 64 == 0)
                cfg_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : ~(32'd1 << $urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            if (cyc % 200 < 100) req_valid = 4'($urandom_range(0, 15));
            else req_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int k = 0; k < 4; k++)
                req_bit[k*5 +: 5] = ($urandom_range(0, 99) < 70) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));

            m_ready = '0; m_g = -1;
            if (!flush && mq.size() < QDEPTH)
                for (int k = 0; k < NREQ; k++)
                    if (m_g < 0 && req_valid[(mptr + k) % NREQ]) m_g = (mptr + k) % NREQ;
            if (m_g >= 0) m_ready[m_g] = 1'b1;
            #1;
            chk("rnd_ready", 32'(req_ready), 32'(m_ready));
            chk("rnd_trig", ep_trigger, mtrig);
            chk("rnd_level", 32'(fifo_level), 32'(mq.size()));
            chk("rnd_busy", 32'(busy), 32'((mq.size() != 0) || (mtrig != 0)));
            chk("rnd_discard", 32'(discard_count), 32'(mdisc));

            // advance the model by one clock
            if (flush) begin
                mq.delete();
                mtrig = '0;
            end else begin
                logic [31:0] ntrig;
                ntrig = '0;
                if (enable && mq.size() > 0) begin
                    int h;
                    h = mq[0];
                    if (!cfg_mask[h]) begin
                        void'(mq.pop_front());
                        if (mdisc < 65535) mdisc++;
                    end else if (mtrig != (32'd1 << h)) begin
                        void'(mq.pop_front());
                        ntrig = 32'd1 << h;
                    end
                end
                if (m_g >= 0) begin
                    mq.push_back(int'((req_bit >> (5 * m_g)) & 20'h1F));
                    mptr = (m_g + 1) % NREQ;
                end
                mtrig = ntrig;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
